// File: rtl/dac_stream_feeder.sv
// Playback buffer between the DDR read path and the RFDC DAC stream: prefills, then
// streams continuously, substituting zero words on underflow and counting them.
module dac_stream_feeder #(
    parameter int unsigned DATA_W  = 256,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned PREFILL = 8
) (
    input  logic                       axi_aclk,
    input  logic                       axi_rstb,
    input  logic [DATA_W-1:0]          s_axis_tdata,
    input  logic [DATA_W/8-1:0]        s_axis_tkeep,
    input  logic                       s_axis_tlast,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    output logic [DATA_W-1:0]          m_axis_tdata,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    input  logic                       play_en,
    input  logic                       clr_status,
    output logic [$clog2(DEPTH):0]     fill_level,
    output logic [15:0]                underflow_cnt,
    output logic                       underflow_flag,
    output logic [15:0]                frame_cnt,
    output logic [1:0]                 play_state
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned KW = DATA_W / 8;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StPrefill = 2'd1,
        StRun     = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_last_q, out_last_d;
    logic              out_valid_q, out_valid_d;
    logic [15:0]       uf_cnt_q, uf_cnt_d;
    logic              uf_flag_q, uf_flag_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;

    // Each entry carries tlast in the top bit above the data.
    logic [DATA_W:0]   mem [DEPTH];
    logic [DATA_W-1:0] wdata_masked;
    logic [DATA_W:0]   head;
    logic              push, pop, flush, underflow, frame_done;

    assign s_axis_tready = (state_q != StIdle) && (count_q != CW'(DEPTH));
    assign push          = s_axis_tvalid && s_axis_tready;
    assign head          = mem[rd_ptr_q[AW-1:0]];
    assign frame_done    = out_valid_q && m_axis_tready && out_last_q;

    always_comb begin
        wdata_masked = '0;
        for (int i = 0; i < KW; i++) begin
            wdata_masked[8*i +: 8] = s_axis_tkeep[i] ? s_axis_tdata[8*i +: 8] : 8'h00;
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (push) begin
            mem[wr_ptr_q[AW-1:0]] <= {s_axis_tlast, wdata_masked};
        end
    end

    always_comb begin
        state_d     = state_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;
        pop         = 1'b0;
        flush       = 1'b0;
        underflow   = 1'b0;
        case (state_q)
            StIdle: begin
                flush       = 1'b1;
                out_valid_d = 1'b0;
                out_data_d  = '0;
                out_last_d  = 1'b0;
                if (play_en) state_d = StPrefill;
            end
            StPrefill, StRun: begin
                if (!play_en) begin
                    state_d     = StIdle;
                    flush       = 1'b1;
                    out_valid_d = 1'b0;
                    out_data_d  = '0;
                    out_last_d  = 1'b0;
                end else if (state_q == StPrefill) begin
                    // Prime the output register so valid and data start together.
                    if (count_q >= CW'(PREFILL)) begin
                        state_d     = StRun;
                        pop         = 1'b1;
                        out_valid_d = 1'b1;
                        {out_last_d, out_data_d} = head;
                    end
                end else if (m_axis_tready) begin
                    if (count_q != '0) begin
                        pop = 1'b1;
                        {out_last_d, out_data_d} = head;
                    end else begin
                        underflow  = 1'b1;
                        out_data_d = '0;
                        out_last_d = 1'b0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        wr_ptr_d = flush ? '0 : wr_ptr_q + CW'(push);
        rd_ptr_d = flush ? '0 : rd_ptr_q + CW'(pop);
        count_d  = flush ? '0 : count_q + CW'(push) - CW'(pop);
    end

    always_comb begin
        uf_cnt_d    = uf_cnt_q;
        uf_flag_d   = uf_flag_q;
        frame_cnt_d = frame_cnt_q;
        if (clr_status) begin
            uf_cnt_d    = '0;
            uf_flag_d   = 1'b0;
            frame_cnt_d = '0;
        end else begin
            if (underflow) begin
                uf_flag_d = 1'b1;
                if (uf_cnt_q != 16'hFFFF) uf_cnt_d = uf_cnt_q + 16'd1;
            end
            if (frame_done && frame_cnt_q != 16'hFFFF) frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_rstb) begin
        if (!axi_rstb) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
            uf_cnt_q    <= '0;
            uf_flag_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
            uf_cnt_q    <= uf_cnt_d;
            uf_flag_q   <= uf_flag_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign m_axis_tdata   = out_data_q;
    assign m_axis_tvalid  = out_valid_q;
    assign fill_level     = count_q;
    assign underflow_cnt  = uf_cnt_q;
    assign underflow_flag = uf_flag_q;
    assign frame_cnt      = frame_cnt_q;
    assign play_state     = state_q;

endmodule

// File: tb/tb_dac_stream_feeder.sv
// Scoreboard bench for dac_stream_feeder: the driver queues expected DAC words, a
// negedge monitor pops and compares every accepted output beat.
module tb_dac_stream_feeder;
    localparam int DW = 256;
    localparam int KW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] s_tdata;
    logic [KW-1:0] s_tkeep;
    logic          s_tlast, s_tvalid, s_tready;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid, m_tready;
    logic          play_en, clr;
    logic [4:0]    fill;
    logic [15:0]   uf_cnt, frame_cnt;
    logic          uf_flag;
    logic [1:0]    play_state;

    logic [DW-1:0] exp_q[$];
    int            compared = 0;
    int            mismatched = 0;

    always #5 clk = ~clk;

    dac_stream_feeder #(.DATA_W(256), .DEPTH(16), .PREFILL(8)) dut (
        .axi_aclk      (clk),
        .axi_rstb      (rst_n),
        .s_axis_tdata  (s_tdata),
        .s_axis_tkeep  (s_tkeep),
        .s_axis_tlast  (s_tlast),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .play_en       (play_en),
        .clr_status    (clr),
        .fill_level    (fill),
        .underflow_cnt (uf_cnt),
        .underflow_flag(uf_flag),
        .frame_cnt     (frame_cnt),
        .play_state    (play_state)
    );

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        compared++;
        mismatched++;
        $display("FAIL %s: got timeout required event", name);
    endtask

    function automatic logic [DW-1:0] word(input int i);
        logic [31:0] v;
        v = 32'hD000_0000 + 32'(i);
        return {8{v}};
    endfunction

    // Monitor: every beat the DAC accepts must match the head of the scoreboard.
    always @(negedge clk) begin
        logic [DW-1:0] e;
        if (rst_n && m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_beat: got %h required none", m_tdata);
            end else begin
                e = exp_q.pop_front();
                check("beat_data", m_tdata, e);
            end
        end
    end

    // Call at posedge+1; returns at posedge+1 after the word was taken.
    task automatic send(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l,
                        input logic [DW-1:0] e);
        int n = 0;
        s_tdata  = d;
        s_tkeep  = k;
        s_tlast  = l;
        s_tvalid = 1'b1;
        @(negedge clk);
        while (!s_tready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) fail_now("send_timeout");
        else exp_q.push_back(e);
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
    endtask

    // Stop playback on the cycle the last expected word is on the output.
    task automatic drain_and_stop();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 300) fail_now("drain_timeout");
        play_en = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got hang required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tlast  = 1'b0;
        m_tready = 1'b1;
        play_en  = 1'b0;
        clr      = 1'b0;
        #12;
        check("rst_tvalid", m_tvalid, 0);
        check("rst_tdata", m_tdata, 0);
        check("rst_s_tready", s_tready, 0);
        check("rst_fill", fill, 0);
        check("rst_status", {uf_cnt, uf_flag, frame_cnt}, 0);
        check("rst_state", play_state, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Prefill then underflow: 8 data words followed by 12 zero words.
        play_en = 1'b1;
        @(posedge clk);
        #1;
        check("prefill_state", play_state, 1);
        for (int i = 0; i < 8; i++) send(word(i), '1, 1'b0, word(i));
        check("prefill_fill8", fill, 8);
        check("prefill_no_valid", m_tvalid, 0);
        for (int i = 0; i < 12; i++) exp_q.push_back('0);
        @(posedge clk);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("run_tvalid", m_tvalid, 1);
            if (i == 0) check("run_state", play_state, 2);
            if (i == 19) play_en = 1'b0;
        end
        @(posedge clk);
        #1;
        check("uf_cnt12", uf_cnt, 12);
        check("uf_flag", uf_flag, 1);
        check("stop1_tvalid", m_tvalid, 0);
        check("uf_queue_empty", exp_q.size(), 0);

        // Full buffer with backpressure, 40 words through a 16-deep buffer.
        m_tready = 1'b0;
        play_en  = 1'b1;
        fork
            begin
                for (int i = 0; i < 40; i++) send(word(100 + i), '1, 1'b0, word(100 + i));
            end
            begin
                int n = 0;
                @(negedge clk);
                while (fill != 5'd16 && n < 200) begin
                    @(negedge clk);
                    n++;
                end
                check("full_fill16", fill, 16);
                check("full_s_tready", s_tready, 0);
                repeat (3) @(negedge clk);
                check("full_hold", fill, 16);
                check("full_tvalid", m_tvalid, 1);
                check("hold_no_underflow", uf_cnt, 12);
                m_tready = 1'b1;
            end
        join
        drain_and_stop();
        check("wrap_no_underflow", uf_cnt, 12);

        // Byte masking and frame counting.
        play_en = 1'b1;
        send({DW{1'b1}}, 32'h0000_FFFF, 1'b0, {128'h0, {128{1'b1}}});
        send(word(200), '1, 1'b1, word(200));
        send(word(201), '1, 1'b0, word(201));
        send(word(202), '1, 1'b1, word(202));
        for (int i = 0; i < 4; i++) send(word(203 + i), '1, 1'b0, word(203 + i));
        drain_and_stop();
        check("frame_cnt2", frame_cnt, 2);

        // Stop with 5 words buffered, restart, clear status.
        play_en  = 1'b1;
        m_tready = 1'b0;
        for (int i = 0; i < 8; i++) send(word(300 + i), '1, 1'b0, word(300 + i));
        @(posedge clk);
        #1;
        check("stop_run_valid", m_tvalid, 1);
        m_tready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        m_tready = 1'b0;
        check("stop_fill5", fill, 5);
        play_en = 1'b0;
        @(posedge clk);
        #1;
        check("stop_tvalid", m_tvalid, 0);
        check("stop_tdata", m_tdata, 0);
        check("stop_fill0", fill, 0);
        check("stop_state", play_state, 0);
        exp_q.delete();
        play_en = 1'b1;
        @(posedge clk);
        #1;
        check("restart_state", play_state, 1);
        check("restart_fill", fill, 0);
        check("status_kept", {uf_cnt, uf_flag, frame_cnt}, {16'd12, 1'b1, 16'd2});
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        check("clr_status", {uf_cnt, uf_flag, frame_cnt}, 0);

        // Asynchronous reset in the middle of RUN.
        m_tready = 1'b1;
        for (int i = 0; i < 8; i++) send(word(400 + i), '1, 1'b0, word(400 + i));
        repeat (3) @(posedge clk);
        #3;
        check("pre_areset_valid", m_tvalid, 1);
        rst_n = 1'b0;
        #1;
        check("areset_tvalid", m_tvalid, 0);
        check("areset_tdata", m_tdata, 0);
        check("areset_state", play_state, 0);
        check("areset_fill", fill, 0);
        exp_q.delete();
        play_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_state", play_state, 0);
        check("post_reset_fill", fill, 0);
        check("post_reset_s_tready", s_tready, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/dac_stream_feeder.md
Name: dac_stream_feeder

Overview:
- Sits directly downstream of the DAC read path; consumes its 256-bit AXI-Stream DDR playback data and drives the RF data converter DAC stream.
- Buffers incoming data and holds the output off until a prefill threshold is reached.
- Once running, presents tvalid continuously, as the RFDC requires.
- On underflow it inserts zero words and records status, so the DAC never sees a stalled stream.

Parameters:
- DATA_W, 256, stream data width in bits (multiple of 8).
- DEPTH, 16, internal buffer depth in words (power of 2, at least 4).
- PREFILL, 8, words buffered before output starts (1..DEPTH).

Ports:
- axi_aclk  in  1  stream clock, 500 MHz.
- axi_rstb  in  1  asynchronous active-low reset.
- s_axis_tdata  in  DATA_W  upstream data.
- s_axis_tkeep  in  DATA_W/8  byte enables.
- s_axis_tlast  in  1  frame end.
- s_axis_tvalid  in  1  upstream valid.
- s_axis_tready  out  1  buffer can accept a word.
- m_axis_tdata  out  DATA_W  RFDC DAC data (registered).
- m_axis_tvalid  out  1  RFDC valid.
- m_axis_tready  in  1  RFDC ready.
- play_en  in  1  level; 1 = play, 0 = stop and flush.
- clr_status  in  1  single-cycle pulse; clears underflow_cnt, underflow_flag and frame_cnt.
- fill_level  out  $clog2(DEPTH)+1  words currently buffered.
- underflow_cnt  out  16  zero words inserted, saturating.
- underflow_flag  out  1  sticky underflow indicator.
- frame_cnt  out  16  tlast words sent to the DAC, saturating.
- play_state  out  2  0 = IDLE, 1 = PREFILL, 2 = RUN.

Behaviour:
- Reset (asynchronous, axi_rstb = 0): all outputs 0; buffer empty; state IDLE.
- Buffer storage: each word stores DATA_W data bits plus tlast. On write, any byte whose tkeep bit is 0 is stored as 0x00.
- Push occurs when s_axis_tvalid && s_axis_tready.
- s_axis_tready = (state != IDLE) && (fill_level != DEPTH). It is combinational from the count.
- At full, a same-cycle pop does not enable a push; no push/pop bypass.
- fill_level updates one cycle after push/pop. Simultaneous push and pop leave it unchanged.
- IDLE:
  - s_axis_tready = 0, m_axis_tvalid = 0.
  - Pointers cleared, m_axis_tdata = 0.
  - play_en = 1 -> PREFILL next cycle.
- PREFILL:
  - Accepts data; m_axis_tvalid = 0.
  - When fill_level >= PREFILL (registered count) -> RUN.
  - On that transition cycle the head word is popped into the output register, so m_axis_tvalid = 1 and valid data appear together on the first RUN cycle.
- RUN:
  - m_axis_tvalid held at 1.
  - Each cycle with m_axis_tready = 1, the output register loads the next word:
    - Buffer non-empty: pop the head word.
    - Buffer empty (underflow): load all-zero data; underflow_cnt increments, saturating at 0xFFFF; underflow_flag sets.
  - m_axis_tready = 0: output register and buffer hold; no underflow is counted.
  - frame_cnt increments (saturating) when a word with tlast = 1 is accepted by the DAC (m_axis_tvalid && m_axis_tready).
- Stop: play_en = 0 in PREFILL or RUN -> IDLE next cycle.
  - Buffer is flushed (pointers reset, contents discarded).
  - m_axis_tvalid = 0 and m_axis_tdata = 0 from that cycle on.
- Status counters survive stop and play; they are cleared only by clr_status or reset.
- clr_status coincident with an increment: clear wins, result 0.
- Pointer wrap-around: natural modulo DEPTH with an extra bit for full/empty discrimination.
- play_state is a registered copy of the state.

Test Plan:
- Prefill: reset, play_en = 1, push 8 words D0..D7 with tkeep all-ones, m_axis_tready = 1.
  - -> m_axis_tvalid rises on the cycle after fill_level reaches 8; output order D0, D1, ...; underflow_cnt = 0.
- Underflow: after prefill, stop upstream for 20 cycles with 8 words buffered.
  - -> 8 data words, then 12 zero words; underflow_cnt = 12; underflow_flag = 1; m_axis_tvalid stays 1 throughout.
- Full buffer and backpressure: m_axis_tready = 0, upstream continuous.
  - -> s_axis_tready drops when fill_level = 16; no data lost or duplicated after m_axis_tready returns; wrap across 40 words verified.
- Byte masking and frames: push word 0xFF..FF with tkeep = 0x0000FFFF, then 3 words with tlast on the 2nd and 4th.
  - -> upper 16 bytes of the first word output as 0; frame_cnt = 2.
- Stop mid-run and clear:
  - Deassert play_en with 5 words buffered -> next cycle m_axis_tvalid = 0, fill_level = 0, play_state = 0.
  - Re-enable -> PREFILL restarts from empty.
  - clr_status pulse -> underflow_cnt, underflow_flag and frame_cnt all 0.
- Async reset mid-RUN: assert axi_rstb = 0 between clock edges.
  - -> outputs 0 immediately; after release, play_state = 0 and the buffer is empty.
